// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
// Holds widths, halt opcode, FSM state enum and the buffer entry layout.
package fetch_pkg;

  localparam int FETCH_ADDR_W = 8;
  localparam int FETCH_DATA_W = 8;
  localparam logic [FETCH_DATA_W-1:0] FETCH_HALT_OPCODE = 8'hFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } state_e;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_DATA_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/fetch_skid_fifo.sv
// 2-entry {pc,data} buffer between IRAM read data and the decoder.
// Ports: clock, reset_n, flush, push/push_data, pop, head, occ.
module fetch_skid_fifo
  import fetch_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       flush,
  input  logic       push,
  input  entry_t     push_data,
  input  logic       pop,
  output entry_t     head,
  output logic [1:0] occ
);

  entry_t [1:0] mem_q, mem_d;
  logic         wptr_q, wptr_d;
  logic         rptr_q, rptr_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         do_push, do_pop;

  always_comb begin
    do_pop  = pop && (cnt_q != 2'd0);
    // a full buffer still accepts a push when the head leaves
    do_push = push && ((cnt_q != 2'd2) || do_pop);
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    if (flush) begin
      wptr_d = 1'b0;
      rptr_d = 1'b0;
      cnt_d  = 2'd0;
    end else begin
      if (do_push) begin
        mem_d[wptr_q] = push_data;
        wptr_d        = !wptr_q;
      end
      if (do_pop) begin
        rptr_d = !rptr_q;
      end
      cnt_d = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      mem_q  <= '0;
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign head = mem_q[rptr_q];
  assign occ  = cnt_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns PC, issues IRAM reads, buffers data for the decoder.
// Ports: clock/reset_n, start/halt/jump ctl, iram_*, ir_* handshake, busy.
// Option: FETCH_HALT_OPCODE_DETECT_EN stops fetching on HALT_OPCODE.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W      = FETCH_ADDR_W,
  parameter int                DATA_W      = FETCH_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter logic [DATA_W-1:0] HALT_OPCODE = FETCH_HALT_OPCODE
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              halt,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic [ADDR_W-1:0] iram_addr,
  output logic              iram_rden,
  input  logic [DATA_W-1:0] iram_q,
  output logic [DATA_W-1:0] ir_data,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic              busy
);

`ifdef FETCH_HALT_OPCODE_DETECT_EN
  localparam bit DETECT_EN = 1'b1;
`else
  localparam bit DETECT_EN = 1'b0;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] infl_pc_q, infl_pc_d;
  logic              infl_q, infl_d;
  logic              jump_go, pop, push, issue, halt_det;
  logic [2:0]        fill;
  logic [1:0]        occ;
  entry_t            push_entry, head;

  // halt beats a simultaneous jump
  assign jump_go  = jump_en && !halt;
  assign pop      = ir_valid && ir_ready;
  // a jump squashes the read returning this cycle
  assign push     = infl_q && !jump_go;
  assign halt_det = DETECT_EN && push && (iram_q == HALT_OPCODE);
  // entries present next cycle if nothing new is issued now
  assign fill     = {1'b0, occ} + {2'b0, infl_q} - {2'b0, pop};

  assign push_entry.pc   = infl_pc_q;
  assign push_entry.data = iram_q;

  fetch_skid_fifo u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (jump_go),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .occ       (occ)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      infl_pc_q <= RESET_PC;
      infl_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      infl_pc_q <= infl_pc_d;
      infl_q    <= infl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = FETCH;
      FETCH:   if (halt || halt_det) state_d = HALTED;
      HALTED:  if (start) state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    issue = (state_q == FETCH) && !jump_en && !halt
            && !halt_det && (fill < 3'd2);
    infl_d    = issue;
    infl_pc_d = issue ? pc_q : infl_pc_q;
    pc_d      = pc_q;
    if (jump_go) begin
      pc_d = jump_addr;
    end else if (halt_det) begin
      pc_d = infl_pc_q + 1'b1;
    end else if (issue) begin
      pc_d = pc_q + 1'b1;
    end
  end

  assign iram_addr = pc_q;
  assign iram_rden = issue;
  assign ir_valid  = (occ != 2'd0);
  assign ir_data   = ir_valid ? head.data : '0;
  assign ir_pc     = ir_valid ? head.pc : '0;
  assign busy      = (state_q == FETCH) || ir_valid || infl_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit with a registered IRAM model.
// Each task drives one scenario and checks outputs against hand values.
module tb_instr_fetch_unit;

  logic       clock = 1'b0;
  logic       reset_n, start, halt, jump_en, ir_ready;
  logic [7:0] jump_addr, iram_addr, iram_q, ir_data, ir_pc;
  logic       iram_rden, ir_valid, busy;

  logic [7:0] mem [256];
  logic [7:0] got_pc [$];
  logic [7:0] got_d [$];
  int         rd_cnt = 0;
  int         total = 0;
  int         bad = 0;

  instr_fetch_unit dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .halt      (halt),
    .jump_en   (jump_en),
    .jump_addr (jump_addr),
    .iram_addr (iram_addr),
    .iram_rden (iram_rden),
    .iram_q    (iram_q),
    .ir_data   (ir_data),
    .ir_pc     (ir_pc),
    .ir_valid  (ir_valid),
    .ir_ready  (ir_ready),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (iram_rden) iram_q <= mem[iram_addr];
  end

  always @(negedge clock) begin
    if (reset_n) begin
      if (ir_valid && ir_ready) begin
        got_pc.push_back(ir_pc);
        got_d.push_back(ir_data);
      end
      if (iram_rden) rd_cnt++;
    end
  end

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clock); #1;
      start = 0; halt = 0; jump_en = 0;
    end
  endtask

  task automatic do_reset;
    reset_n = 0; start = 0; halt = 0; jump_en = 0;
    jump_addr = 0; ir_ready = 0;
    @(posedge clock); #1;
    @(posedge clock); #1;
  endtask

  task automatic test_reset;
    do_reset();
    #1;
    total++; if (ir_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b exp=0", ir_valid); end
    total++; if (ir_data !== 8'h00) begin bad++; $display("FAIL rst_data got=%0h exp=0", ir_data); end
    total++; if (ir_pc !== 8'h00) begin bad++; $display("FAIL rst_pc got=%0h exp=0", ir_pc); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b exp=0", busy); end
    total++; if (iram_rden !== 1'b0) begin bad++; $display("FAIL rst_rden got=%0b exp=0", iram_rden); end
    total++; if (iram_addr !== 8'h00) begin bad++; $display("FAIL rst_addr got=%0h exp=0", iram_addr); end
  endtask

  task automatic test_basic;
    logic [7:0] ed [4];
    ed[0] = 8'h11; ed[1] = 8'h22; ed[2] = 8'h33; ed[3] = 8'h44;
    do_reset();
    reset_n = 1; start = 1; ir_ready = 1;
    for (int c = 0; c < 7; c++) begin
      #1;
      total++;
      if (iram_rden !== 1'(c >= 1)) begin
        bad++; $display("FAIL basic_rden c=%0d got=%0b exp=%0b", c, iram_rden, c >= 1);
      end
      if (c >= 1) begin
        total++;
        if (iram_addr !== 8'(c - 1)) begin
          bad++; $display("FAIL basic_addr c=%0d got=%0h exp=%0h", c, iram_addr, c - 1);
        end
      end
      total++;
      if (ir_valid !== 1'(c >= 3)) begin
        bad++; $display("FAIL basic_valid c=%0d got=%0b exp=%0b", c, ir_valid, c >= 3);
      end
      if (c >= 3) begin
        total++;
        if (ir_pc !== 8'(c - 3) || ir_data !== ed[c-3]) begin
          bad++; $display("FAIL basic_out c=%0d got=%0h/%0h exp=%0h/%0h", c, ir_pc, ir_data, c - 3, ed[c-3]);
        end
      end
      @(posedge clock); #1;
      start = 0;
    end
  endtask

  task automatic test_stall;
    int rd0, p0, n;
    do_reset();
    rd0 = rd_cnt; p0 = got_pc.size();
    reset_n = 1; start = 1; ir_ready = 1;
    run(6);
    ir_ready = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      total++;
      if (ir_valid !== 1'b1 || ir_pc !== 8'(got_pc.size() - p0)) begin
        bad++; $display("FAIL stall_hold k=%0d got=%0b/%0h exp=1/%0h", k, ir_valid, ir_pc, got_pc.size() - p0);
      end
      @(posedge clock); #1;
    end
    n = (rd_cnt - rd0) - (got_pc.size() - p0);
    total++; if (n != 2) begin bad++; $display("FAIL stall_outstanding got=%0d exp=2", n); end
    ir_ready = 1;
    run(8);
    halt = 1;
    run(5);
    n = got_pc.size() - p0;
    total++; if (n != rd_cnt - rd0) begin bad++; $display("FAIL stall_count got=%0d exp=%0d", n, rd_cnt - rd0); end
    for (int i = 0; i < n; i++) begin
      total++;
      if (got_pc[p0+i] !== 8'(i) || got_d[p0+i] !== mem[i]) begin
        bad++; $display("FAIL stall_seq i=%0d got=%0h/%0h exp=%0h/%0h", i, got_pc[p0+i], got_d[p0+i], i, mem[i]);
      end
    end
  endtask

  task automatic test_jump;
    int p1;
    do_reset();
    reset_n = 1; start = 1; ir_ready = 1;
    run(6);
    jump_en = 1; jump_addr = 8'h80;
    run(1);
    #1;
    total++; if (ir_valid !== 1'b0) begin bad++; $display("FAIL jump_flush got=%0b exp=0", ir_valid); end
    total++;
    if (iram_rden !== 1'b1 || iram_addr !== 8'h80) begin
      bad++; $display("FAIL jump_issue got=%0b/%0h exp=1/80", iram_rden, iram_addr);
    end
    p1 = got_pc.size();
    run(6);
    halt = 1;
    run(4);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (got_pc[p1+i] !== 8'(8'h80 + i) || got_d[p1+i] !== mem[8'h80+i]) begin
        bad++; $display("FAIL jump_seq i=%0d got=%0h/%0h exp=%0h/%0h", i, got_pc[p1+i], got_d[p1+i], 8'h80 + i, mem[8'h80+i]);
      end
    end
  endtask

  task automatic test_wrap;
    int p1;
    logic [7:0] ep [4];
    ep[0] = 8'hFE; ep[1] = 8'hFF; ep[2] = 8'h00; ep[3] = 8'h01;
    do_reset();
    reset_n = 1; start = 1; jump_en = 1; jump_addr = 8'hFE; ir_ready = 1;
    #1;
    total++; if (iram_rden !== 1'b0) begin bad++; $display("FAIL wrap_idle got=%0b exp=0", iram_rden); end
    p1 = got_pc.size();
    run(1);
    #1;
    total++;
    if (iram_rden !== 1'b1 || iram_addr !== 8'hFE) begin
      bad++; $display("FAIL wrap_first got=%0b/%0h exp=1/fe", iram_rden, iram_addr);
    end
    run(6);
    halt = 1;
    run(4);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (got_pc[p1+i] !== ep[i] || got_d[p1+i] !== mem[ep[i]]) begin
        bad++; $display("FAIL wrap_seq i=%0d got=%0h/%0h exp=%0h/%0h", i, got_pc[p1+i], got_d[p1+i], ep[i], mem[ep[i]]);
      end
    end
  endtask

  task automatic test_halt;
    int rd0, p0, n;
    do_reset();
    rd0 = rd_cnt; p0 = got_pc.size();
    reset_n = 1; ir_ready = 1;
    for (int c = 0; c < 21; c++) begin
      start = (c == 0 || c == 12);
      halt = (c == 6);
      #1;
      if (c >= 6 && c <= 12) begin
        total++;
        if (iram_rden !== 1'b0) begin bad++; $display("FAIL halt_rden c=%0d got=1 exp=0", c); end
      end
      if (c == 8) begin
        total++;
        if (iram_addr !== 8'h05) begin bad++; $display("FAIL halt_pc got=%0h exp=05", iram_addr); end
      end
      @(posedge clock); #1;
    end
    start = 0; halt = 1;
    run(5);
    n = got_pc.size() - p0;
    total++; if (n != rd_cnt - rd0) begin bad++; $display("FAIL halt_count got=%0d exp=%0d", n, rd_cnt - rd0); end
    for (int i = 0; i < n; i++) begin
      total++;
      if (got_pc[p0+i] !== 8'(i) || got_d[p0+i] !== mem[i]) begin
        bad++; $display("FAIL halt_seq i=%0d got=%0h/%0h exp=%0h/%0h", i, got_pc[p0+i], got_d[p0+i], i, mem[i]);
      end
    end
  endtask

  task automatic test_opcode;
    int p0, n;
    mem[5] = 8'hFF;
    do_reset();
    p0 = got_pc.size();
    reset_n = 1; start = 1; ir_ready = 1;
    run(14);
    #1;
    n = got_pc.size() - p0;
    total++;
    if (got_d[p0+5] !== 8'hFF) begin bad++; $display("FAIL op_data got=%0h exp=ff", got_d[p0+5]); end
`ifdef FETCH_HALT_OPCODE_DETECT_EN
    total++; if (n != 6) begin bad++; $display("FAIL op_count got=%0d exp=6", n); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL op_busy got=%0b exp=0", busy); end
    total++; if (iram_addr !== 8'h06) begin bad++; $display("FAIL op_pc got=%0h exp=06", iram_addr); end
`else
    total++; if (n <= 6) begin bad++; $display("FAIL op_count got=%0d exp=>6", n); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL op_busy got=%0b exp=1", busy); end
`endif
    for (int i = 0; i < 6; i++) begin
      total++;
      if (got_pc[p0+i] !== 8'(i)) begin bad++; $display("FAIL op_seq i=%0d got=%0h exp=%0h", i, got_pc[p0+i], i); end
    end
    halt = 1;
    run(4);
    mem[5] = 8'h05 ^ 8'h5A;
  endtask

  task automatic test_midreset;
    int p1;
    do_reset();
    reset_n = 1; start = 1; ir_ready = 1;
    run(5);
    reset_n = 0;
    run(1);
    reset_n = 1;
    #1;
    total++; if (ir_valid !== 1'b0) begin bad++; $display("FAIL mr_valid got=%0b exp=0", ir_valid); end
    total++; if (ir_data !== 8'h00 || ir_pc !== 8'h00) begin bad++; $display("FAIL mr_out got=%0h/%0h exp=0/0", ir_data, ir_pc); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mr_busy got=%0b exp=0", busy); end
    total++; if (iram_rden !== 1'b0 || iram_addr !== 8'h00) begin bad++; $display("FAIL mr_iram got=%0b/%0h exp=0/0", iram_rden, iram_addr); end
    p1 = got_pc.size();
    for (int k = 0; k < 4; k++) begin
      @(posedge clock); #2;
      total++;
      if (ir_valid !== 1'b0) begin bad++; $display("FAIL mr_stale k=%0d got=1 exp=0", k); end
    end
    total++; if (got_pc.size() != p1) begin bad++; $display("FAIL mr_pops got=%0d exp=%0d", got_pc.size(), p1); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    test_reset();
    test_basic();
    test_stall();
    test_jump();
    test_wrap();
    test_halt();
    test_opcode();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage sitting directly downstream of the 256x8 instruction RAM.
- Owns the program counter and drives the IRAM read address and read enable.
- Captures the 1-cycle-latency registered read data into a 2-entry buffer.
- Presents instructions to the decoder over a valid/ready handshake, with start, halt and jump control.

Parameters:
- ADDR_W, 8, PC / IRAM address width.
- DATA_W, 8, instruction width.
- RESET_PC, 8'h00, PC value after reset.
- HALT_OPCODE, 8'hFF, opcode recognised by the optional auto-halt feature.

Ports:
- clock  in  1  system clock, all state on posedge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  pulse: begin or resume fetching from the current PC.
- halt  in  1  pulse: stop issuing new reads.
- jump_en  in  1  load PC from jump_addr and flush.
- jump_addr  in  ADDR_W  jump target.
- iram_addr  out  ADDR_W  IRAM read address (combinational = PC).
- iram_rden  out  1  IRAM read enable (combinational issue strobe).
- iram_q  in  DATA_W  IRAM registered read data.
- ir_data  out  DATA_W  instruction at buffer head.
- ir_pc  out  ADDR_W  address of ir_data.
- ir_valid  out  1  buffer head valid.
- ir_ready  in  1  decoder accepts head.
- busy  out  1  state==FETCH, or buffer non-empty, or read in flight.

Behaviour:
- Reset (reset_n=0 at posedge):
  - state=IDLE, PC=RESET_PC, buffer empty, inflight=0.
  - ir_valid=0, ir_data=0, ir_pc=0, busy=0.
  - iram_rden=0, iram_addr=RESET_PC.
  - An iram_q arriving the cycle after reset is discarded.
- States and transitions:
  - IDLE: start -> FETCH.
  - FETCH: halt -> HALTED.
  - HALTED: start -> FETCH.
  - start while in FETCH is ignored.
- Issue rule:
  - Issue when state==FETCH && !jump_en && !halt && (occ + inflight - pop) < 2, where pop = ir_valid && ir_ready.
  - Issue drives iram_rden=1 with iram_addr=PC.
  - Issue sets inflight for the next cycle; PC<=PC+1, wrapping 8'hFF->8'h00.
- Read latency:
  - Data issued in cycle t is valid on iram_q in cycle t+1.
  - It is written into the buffer tail as {pc, data} at the end of t+1.
  - ir_valid is high from t+2 at the earliest.
- Throughput:
  - With ir_ready held high, sustained rate is one instruction per cycle.
  - With ir_ready low, at most 2 entries are buffered; no read is dropped.
- Handshake:
  - ir_data and ir_pc are stable while ir_valid && !ir_ready.
  - A pop and a push in the same cycle are both performed.
- Jump (jump_en=1):
  - Buffer is flushed and any in-flight read is squashed (its iram_q is ignored next cycle).
  - PC<=jump_addr; no issue that cycle.
  - Issue from jump_addr the next cycle if in FETCH.
  - Jump is accepted in any state; in IDLE/HALTED it only loads PC.
- Halt:
  - Issue stops immediately.
  - The in-flight read still completes into the buffer; buffered entries are still delivered.
  - PC holds the next unissued address.
- Simultaneous halt+jump_en: halt wins, jump ignored.
- Simultaneous start+jump_en in IDLE: PC loaded, state->FETCH, first issue next cycle.

Optional Feature:
- Macro: FETCH_HALT_OPCODE_DETECT_EN.
- Defined:
  - When a pushed instruction equals HALT_OPCODE, state->HALTED that cycle.
  - Any in-flight read issued after it is squashed.
  - PC is set to halt_pc+1.
  - The halt instruction itself is still delivered to the decoder.
- Undefined: HALT_OPCODE is treated as an ordinary instruction; only the halt port stops fetching.

Decomposition:
- Package fetch_pkg:
  - ADDR_W/DATA_W defaults.
  - State enum {IDLE, FETCH, HALTED}.
  - HALT_OPCODE default.
  - Buffer entry struct {pc, data}.
- One sub-module, fetch_skid_fifo:
  - 2-entry {pc, data} FIFO with push/pop, occupancy output and synchronous flush.
  - The top holds PC, FSM, inflight flag and issue logic.

Test Plan:
- Reset then start, ir_ready=1, IRAM at 0..3 = 8'h11,22,33,44 -> iram_rden high from cycle 1; ir_valid from cycle 3; ir_data 11,22,33,44 on consecutive cycles; ir_pc 0,1,2,3.
- ir_ready low for 5 cycles mid-stream -> at most 2 reads issued beyond the last pop; no lost or duplicate instructions; order preserved on release.
- jump_en with jump_addr=8'h80 while buffer full and read in flight -> ir_valid drops next cycle; next delivered ir_pc=8'h80.
- PC at 8'hFE, free-run -> ir_pc sequence FE, FF, 00, 01.
- halt at cycle 6, then start at cycle 12 -> no iram_rden in 7..12; delivered stream contiguous with no gap in ir_pc.
- With FETCH_HALT_OPCODE_DETECT_EN: 8'hFF at address 5 -> instructions 0..5 delivered; state HALTED; busy=0 after drain; PC=6.
- Reset asserted mid-stream -> all outputs at reset values next cycle; no stale instruction is ever delivered.
